// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and direct MTHI/MTLO writes.
module muldiv_unit #(
    parameter int WIDE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [WIDE-1:0] a,
    input  logic [WIDE-1:0] b,
    input  logic            we_hi,
    input  logic            we_lo,
    input  logic [WIDE-1:0] wd,
    output logic            busy,
    output logic            done,
    output logic            dz,
    output logic [WIDE-1:0] hi,
    output logic [WIDE-1:0] lo
);
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
    state_t            state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [2*WIDE-1:0] acc_q, acc_d;
    logic [WIDE-1:0]   opb_q, opb_d, hi_q, hi_d, lo_q, lo_d;
    logic              qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d, div_q, div_d;
    logic              accept;
    logic [WIDE-1:0]   mag_a, mag_b, fix_q, fix_r;
    logic [WIDE:0]     mul_sum, div_diff;
    logic [2*WIDE-1:0] fix_prod;
    assign busy = state_q inside {MUL, DIV, FIX};
    assign done = state_q == DONE;
    assign dz   = done && dz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
    // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    always_comb begin
        accept   = start && (state_q == IDLE || state_q == DONE);
        mag_a    = (op[0] && a[WIDE-1]) ? -a : a;
        mag_b    = (op[0] && b[WIDE-1]) ? -b : b;
        mul_sum  = {1'b0, acc_q[2*WIDE-1:WIDE]} + (acc_q[0] ? {1'b0, opb_q} : {(WIDE+1){1'b0}});
        div_diff = acc_q[2*WIDE-1:WIDE-1] - {1'b0, opb_q};
        fix_prod = qneg_q ? -acc_q : acc_q;
        fix_q    = dz_q ? {WIDE{1'b1}} : qneg_q ? -acc_q[WIDE-1:0] : acc_q[WIDE-1:0];
        fix_r    = rneg_q ? -acc_q[2*WIDE-1:WIDE] : acc_q[2*WIDE-1:WIDE];
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        div_d    = div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            MUL, DIV: begin
                acc_d   = (state_q == MUL) ? {mul_sum, acc_q[WIDE-1:1]} :
                          div_diff[WIDE] ? {acc_q[2*WIDE-2:0], 1'b0} :
                          {div_diff[WIDE-1:0], acc_q[WIDE-2:0], 1'b1};
                cnt_d   = cnt_q + 6'd1;
                state_d = (cnt_q == 6'(WIDE - 1)) ? FIX : state_q;
            end
            FIX: begin
                state_d      = DONE;
                {hi_d, lo_d} = div_q ? {fix_r, fix_q} : fix_prod;
            end
            DONE:    state_d = IDLE;
            default: ;
        endcase
        if (accept) begin
            state_d = op[1] ? DIV : MUL;
            cnt_d   = 6'd0;
            acc_d   = {{WIDE{1'b0}}, mag_a};
            opb_d   = mag_b;
            qneg_d  = op[0] && (a[WIDE-1] ^ b[WIDE-1]);
            rneg_d  = op[0] && a[WIDE-1];
            dz_d    = op[1] && (b == '0);
            div_d   = op[1];
        end
        // divide-by-zero still runs the full iteration: the remainder then equals |a|, re-signed back to a
        hi_d = (!busy && we_hi) ? wd : hi_d;
        lo_d = (!busy && we_lo) ? wd : lo_d;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            div_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    localparam int WIDE = 32;
    typedef struct {
        logic [WIDE-1:0] hi;
        logic [WIDE-1:0] lo;
        logic            dz;
        int unsigned     t;
    } exp_t;
    logic            clk = 1'b0, rst = 1'b1, start = 1'b0, we_hi = 1'b0, we_lo = 1'b0;
    logic [1:0]      op = '0;
    logic [WIDE-1:0] a = '0, b = '0, wd = '0;
    logic            busy, done, dz;
    logic [WIDE-1:0] hi, lo;
    exp_t            sb[$];
    exp_t            mon_e;
    int unsigned     cyc = 0;
    int              n_cmp = 0, n_fail = 0;
    muldiv_unit #(.WIDE(WIDE)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .we_hi(we_hi), .we_lo(we_lo), .wd(wd),
        .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask
    function automatic exp_t model(input logic [1:0] o, input logic [WIDE-1:0] x, input logic [WIDE-1:0] y,
                                   input int unsigned t);
        exp_t        e;
        logic [63:0] p;
        int          sx, sy;
        e.t  = t;
        e.dz = 1'b0;
        if (!o[1]) begin
            p = o[0] ? 64'(longint'($signed(x)) * longint'($signed(y))) : 64'(x) * 64'(y);
            {e.hi, e.lo} = p;
        end else if (y == 0) begin
            e.dz = 1'b1;
            e.hi = x;
            e.lo = '1;
        end else if (!o[0]) begin
            e.lo = x / y;
            e.hi = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            e.lo = x;
            e.hi = '0;
        end else begin
            sx   = x;
            sy   = y;
            e.lo = 32'(sx / sy);
            e.hi = 32'(sx % sy);
        end
        return e;
    endfunction
    function automatic logic [WIDE-1:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            4:       return 32'(int'($urandom_range(0, 20)) - 10);
            default: return $urandom;
        endcase
    endfunction
    // called at a falling edge; the operation is accepted on the next rising edge
    task automatic launch(input logic [1:0] o, input logic [WIDE-1:0] x, input logic [WIDE-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        sb.push_back(model(o, x, y, cyc + 1 + WIDE + 1));
        @(negedge clk);
        start = 1'b0;
    endtask
    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 64'(done), 64'd1);
    endtask
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("hi", 64'(hi), 64'(mon_e.hi));
                    chk("lo", 64'(lo), 64'(mon_e.lo));
                    chk("dz", 64'(dz), 64'(mon_e.dz));
                    chk("done_cycle", 64'(cyc), 64'(mon_e.t));
                end
            end else begin
                chk("dz_outside_done", 64'(dz), 64'd0);
            end
        end
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
    initial begin
        int nb;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dz", 64'(dz), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        rst = 1'b0;
        launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        nb = 0;
        while (busy && nb < 200) begin
            nb++;
            @(negedge clk);
        end
        chk("busy_cycles", 64'(nb), 64'd33);
        chk("done_after_busy", 64'(done), 64'd1);
        @(negedge clk);
        launch(2'b01, 32'hFFFF_FFFD, 32'd5);
        wait_done();
        launch(2'b11, 32'hFFFF_FFF9, 32'd2);
        wait_done();
        @(negedge clk);
        launch(2'b10, 32'd100, 32'd0);
        wait_done();
        @(negedge clk);
        launch(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done();
        @(negedge clk);
        launch(2'b00, 32'd7, 32'd9);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd1; b = 32'd1; we_lo = 1'b1; wd = 32'h55;
        @(negedge clk);
        start = 1'b0; we_lo = 1'b0;
        chk("busy_ignore_we_lo", 64'(lo), 64'h8000_0000);
        chk("busy_still", 64'(busy), 64'd1);
        wait_done();
        @(negedge clk);
        launch(2'b00, 32'd7, 32'd9);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_hilo", {hi, lo}, 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (45) @(negedge clk);
        chk("no_done_after_rst", 64'(done), 64'd0);
        chk("hilo_after_abandon", {hi, lo}, 64'd0);
        we_hi = 1'b1; wd = 32'h1234;
        @(negedge clk);
        we_hi = 1'b0;
        chk("mthi_idle", 64'(hi), 64'h1234);
        we_lo = 1'b1; wd = 32'hABCD;
        @(negedge clk);
        we_lo = 1'b0;
        chk("mtlo_idle", 64'(lo), 64'hABCD);
        we_hi = 1'b1; wd = 32'h77;
        launch(2'b00, 32'd2, 32'd3);
        we_hi = 1'b0;
        chk("start_with_mthi", 64'(hi), 64'h77);
        chk("start_with_mthi_busy", 64'(busy), 64'd1);
        we_lo = 1'b1; wd = 32'h99;
        @(negedge clk);
        we_lo = 1'b0;
        chk("mtlo_busy_ignored", 64'(lo), 64'hABCD);
        wait_done();
        @(negedge clk);
        repeat (150) begin
            launch(2'($urandom_range(0, 3)), rnd_opnd(), rnd_opnd());
            wait_done();
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
